// File: rtl/ladder_step_counter.sv
// Up/down step counter with wrap, saturate and ping-pong modes.
// All outputs are registered; dir_o is the ping-pong FSM state.
module ladder_step_counter #(
  parameter int WIDTH     = 4,
  parameter int DELTA_W   = 3,
  parameter int RESET_VAL = 0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               en,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [DELTA_W-1:0] delta,
  input  logic [1:0]         mode,
  output logic [WIDTH-1:0]   count,
  output logic               dir_o,
  output logic               wrap_p,
  output logic               sat_o
);

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MAX_EXT   = {1'b0, {WIDTH{1'b1}}};

  dir_t           state, next_state;
  logic [WIDTH-1:0] next_count;
  logic           next_wrap, next_sat;
  logic [WIDTH:0] delta_ext, sum_ext, diff_ext;

  // One extra bit: sum carry means overflow, difference MSB means borrow.
  always_comb begin
    delta_ext = (WIDTH+1)'(delta);
    sum_ext   = {1'b0, count} + delta_ext;
    diff_ext  = {1'b0, count} - delta_ext;
  end

  // A zero step is a full no-op in every mode, including the direction state.
  always_comb begin
    next_count = count;
    next_state = state;
    next_wrap  = 1'b0;
    next_sat   = 1'b0;
    if (load) begin
      next_count = load_val;
    end else if (en && (delta_ext != '0)) begin
      case (mode)
        2'b00: begin
          next_count = sum_ext[WIDTH-1:0];
          next_wrap  = sum_ext[WIDTH];
          next_state = UP;
        end
        2'b01: begin
          next_count = diff_ext[WIDTH-1:0];
          next_wrap  = diff_ext[WIDTH];
          next_state = UP;
        end
        2'b10: begin
          next_state = UP;
          if (sum_ext > MAX_EXT) begin
            next_count = MAX_EXT[WIDTH-1:0];
            next_sat   = 1'b1;
          end else begin
            next_count = sum_ext[WIDTH-1:0];
          end
        end
        2'b11: begin
          if (state == UP) begin
            if (sum_ext >= MAX_EXT) begin
              next_count = MAX_EXT[WIDTH-1:0];
              next_state = DOWN;
              next_wrap  = 1'b1;
            end else begin
              next_count = sum_ext[WIDTH-1:0];
            end
          end else begin
            if (delta_ext >= {1'b0, count}) begin
              next_count = '0;
              next_state = UP;
              next_wrap  = 1'b1;
            end else begin
              next_count = diff_ext[WIDTH-1:0];
            end
          end
        end
        default: begin
          next_count = count;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count  <= RESET_CNT;
      state  <= UP;
      wrap_p <= 1'b0;
      sat_o  <= 1'b0;
    end else begin
      count  <= next_count;
      state  <= next_state;
      wrap_p <= next_wrap;
      sat_o  <= next_sat;
    end
  end

  assign dir_o = state;

endmodule
